brupd_queue: RTL and testbench

- Sits directly downstream of the branch execution unit.
- Each cycle that unit asserts rob_we, this block captures the resolved branch outcome: pc, taken target, condition and mispredict flag.
- Outcomes are buffered in a small FIFO and drained to the branch predictor (BTB/PHT) update port over a valid/ready handshake.
- The execution unit cannot stall, so the block gives back-pressure to branch issue via an almost-full flag and counts any outcomes it has to drop.

---
 rtl/brupd_queue.sv | 123 ++++++++++++
 tb/tb_brupd_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/brupd_queue.sv
// Branch-outcome FIFO between the branch execution unit and predictor update.
// Ports: ex_* capture in, upd_* valid/ready drain out, bq_almost_full, drop_cnt
//        (+ stat_br_cnt/stat_miss_cnt when BRUPD_STAT_EN is defined).
module brupd_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [ADDR_LEN-1:0] ex_pc,
  input  logic [ADDR_LEN-1:0] ex_jmpaddr_taken,
  input  logic                ex_brcond,
  input  logic                ex_prmiss,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [ADDR_LEN-1:0] upd_pc,
  output logic [ADDR_LEN-1:0] upd_jmpaddr,
  output logic                upd_brcond,
  output logic                upd_prmiss,
  output logic                bq_almost_full,
  output logic [7:0]          drop_cnt
`ifdef BRUPD_STAT_EN
  ,
  output logic [31:0]         stat_br_cnt,
  output logic [31:0]         stat_miss_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t CNT_AF   = cnt_t'(DEPTH - 1);

  logic [ADDR_LEN-1:0] pc_q [DEPTH];
  logic [ADDR_LEN-1:0] tg_q [DEPTH];
  logic                bc_q [DEPTH];
  logic                pm_q [DEPTH];

  ptr_t wp_q, wp_d;
  ptr_t rp_q, rp_d;
  cnt_t cnt_q, cnt_d;
  logic [7:0] drop_q, drop_d;

  logic push, pop, full, drop;

  always_comb begin
    full  = (cnt_q == CNT_FULL);
    pop   = (cnt_q != '0) & upd_ready;
    // A full queue still accepts when the head leaves this cycle.
    push  = ex_valid & (~full | pop);
    drop  = ex_valid & ~push;
    wp_d  = push ? wp_q + ptr_t'(1) : wp_q;
    rp_d  = pop  ? rp_q + ptr_t'(1) : rp_q;
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        tg_q[i] <= '0;
        bc_q[i] <= 1'b0;
        pm_q[i] <= 1'b0;
      end
    end else if (push) begin
      pc_q[wp_q] <= ex_pc;
      tg_q[wp_q] <= ex_jmpaddr_taken;
      bc_q[wp_q] <= ex_brcond;
      pm_q[wp_q] <= ex_prmiss;
    end
  end

  assign upd_valid      = (cnt_q != '0);
  assign upd_pc         = pc_q[rp_q];
  assign upd_jmpaddr    = tg_q[rp_q];
  assign upd_brcond     = bc_q[rp_q];
  assign upd_prmiss     = pm_q[rp_q];
  assign bq_almost_full = (cnt_q >= CNT_AF);
  assign drop_cnt       = drop_q;

`ifdef BRUPD_STAT_EN
  logic [31:0] br_q, miss_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_q   <= '0;
      miss_q <= '0;
    end else if (push) begin
      br_q <= br_q + 32'd1;
      if (ex_prmiss) miss_q <= miss_q + 32'd1;
    end
  end

  assign stat_br_cnt   = br_q;
  assign stat_miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_brupd_queue.sv
// Directed + random bench for brupd_queue against a queue-based model.
// Summary: "test done: total=N bad=M".
module tb_brupd_queue;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_jmpaddr_taken;
  logic        ex_brcond;
  logic        ex_prmiss;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_pc;
  logic [31:0] upd_jmpaddr;
  logic        upd_brcond;
  logic        upd_prmiss;
  logic        bq_almost_full;
  logic [7:0]  drop_cnt;
`ifdef BRUPD_STAT_EN
  logic [31:0] stat_br_cnt;
  logic [31:0] stat_miss_cnt;
`endif

  brupd_queue #(.DEPTH(D), .ADDR_LEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_jmpaddr_taken (ex_jmpaddr_taken),
    .ex_brcond        (ex_brcond),
    .ex_prmiss        (ex_prmiss),
    .upd_valid        (upd_valid),
    .upd_ready        (upd_ready),
    .upd_pc           (upd_pc),
    .upd_jmpaddr      (upd_jmpaddr),
    .upd_brcond       (upd_brcond),
    .upd_prmiss       (upd_prmiss),
    .bq_almost_full   (bq_almost_full),
    .drop_cnt         (drop_cnt)
`ifdef BRUPD_STAT_EN
    ,
    .stat_br_cnt      (stat_br_cnt),
    .stat_miss_cnt    (stat_miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tg;
    logic        bc;
    logic        pm;
  } ent_t;

  ent_t q[$];
  int   mdrop;
  int   mbr;
  int   mmiss;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    chk("upd_valid", 64'(upd_valid), 64'(q.size() != 0));
    chk("almost_full", 64'(bq_almost_full), 64'(q.size() >= D - 1));
    chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
    if (q.size() != 0) begin
      chk("upd_pc", 64'(upd_pc), 64'(q[0].pc));
      chk("upd_jmpaddr", 64'(upd_jmpaddr), 64'(q[0].tg));
      chk("upd_brcond", 64'(upd_brcond), 64'(q[0].bc));
      chk("upd_prmiss", 64'(upd_prmiss), 64'(q[0].pm));
    end
`ifdef BRUPD_STAT_EN
    chk("stat_br", 64'(stat_br_cnt), 64'(mbr));
    chk("stat_miss", 64'(stat_miss_cnt), 64'(mmiss));
`endif
  endtask

  // One clock: apply inputs, check pre-edge outputs, advance model and DUT.
  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic [31:0] tg, input logic bc,
                     input logic pm, input logic rdy);
    bit   pop;
    ent_t e;
    ex_valid         = v;
    ex_pc            = pc;
    ex_jmpaddr_taken = tg;
    ex_brcond        = bc;
    ex_prmiss        = pm;
    upd_ready        = rdy;
    @(negedge clk);
    check_outs();
    pop = (q.size() != 0) && rdy;
    if (v && (q.size() < D || pop)) begin
      e.pc = pc; e.tg = tg; e.bc = bc; e.pm = pm;
      if (pop) void'(q.pop_front());
      q.push_back(e);
      mbr++;
      if (pm) mmiss++;
    end else begin
      if (pop) void'(q.pop_front());
      if (v && mdrop < 255) mdrop++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear at once.
  task automatic rst();
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(upd_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_afull", 64'(bq_almost_full), 64'd0);
    chk("rst_pc", 64'(upd_pc), 64'd0);
    q.delete();
    mdrop = 0;
    mbr   = 0;
    mmiss = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    ex_valid = 0; ex_pc = 0; ex_jmpaddr_taken = 0;
    ex_brcond = 0; ex_prmiss = 0; upd_ready = 0;
    rst();
    idle(1'b0);

    // single push, held while stalled, then accepted
    cyc(1'b1, 32'h100, 32'h180, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // fill, overflow drop, drain in order
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 32'(i * 16), 32'(i * 16 + 8), 1'(i & 1), 1'b0, 1'b0);
    cyc(1'b1, 32'h50, 32'h58, 1'b1, 1'b1, 1'b0);
    chk("drop_after_5th", 64'(drop_cnt), 64'd1);
    // push and pop while full: no drop
    cyc(1'b1, 32'h60, 32'h68, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // continuous streaming across pointer wrap
    rst();
    for (int i = 0; i < 10; i++)
      cyc(1'b1, 32'(i * 4), 32'(i * 4 + 32'h1000), 1'b1, 1'(i % 3 == 0),
          1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("stream_drop", 64'(drop_cnt), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
          1'($urandom), 1'($urandom), 1'($urandom_range(0, 99) < 45));

    // drop counter saturation
    for (int i = 0; i < 270; i++)
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0, 1'b0);
    chk("drop_sat", 64'(drop_cnt), 64'd255);
    idle(1'b1);

    // reset with entries queued
    chk("pre_rst_valid", 64'(upd_valid), 64'd1);
    rst();
    idle(1'b1);

    // statistics: 5 pushes, 2 mispredicted
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'(i * 8), 32'(i * 8 + 4), 1'b1, 1'(i == 1 || i == 3),
          1'b1);
    idle(1'b1);
`ifdef BRUPD_STAT_EN
    chk("stat_br_5", 64'(stat_br_cnt), 64'd5);
    chk("stat_miss_2", 64'(stat_miss_cnt), 64'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
